cm148_req_encoder: RTL

Sequential 8-to-3 priority encoder: the encode-side counterpart of the 3-to-8 active-low line decoder. It takes eight asynchronous active-low request lines, synchronizes them, latches falling edges as pending requests, and presents one request at a time as a 3-bit code. Each code is offered on a valid/ready handshake, and the granted request is retired on acceptance. It sits between external or decoded request lines and a consumer that services one index per transfer.

---
 rtl/cm148_req_encoder.sv | 66 ++++++
 1 files changed

// File: rtl/cm148_req_encoder.sv
// cm148_req_encoder: synchronized falling-edge request capture with fixed-priority or round-robin
// 8-to-3 encoding, one code per valid/ready transfer
module cm148_req_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter bit RR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_n,
  input  logic       en_n,
  input  logic       out_ready,
  output logic [2:0] code,
  output logic       out_valid,
  output logic       gs_n,
  output logic       ovf
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_next;
  logic [SYNC_STAGES-1:0][7:0] sync;
  logic [7:0] sd, fall, pend, pend_next, clr;
  logic [2:0] last, sel, idx;
  logic hs, load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '1;
      sd <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_n};
      sd <= sync[SYNC_STAGES-1];
    end
  assign fall = ~sync[SYNC_STAGES-1] & sd;
  assign hs = state == PRESENT && out_ready;
  assign clr = hs ? 8'd1 << code : 8'd0;
  // a new edge on the bit being retired wins over the clear
  assign pend_next = (pend & ~clr) | fall;
  assign load = state == IDLE && !en_n && |pend;
  assign out_valid = state == PRESENT;
  always_comb begin
    state_next = load ? PRESENT : hs ? IDLE : state;
  end
  // later iterations overwrite earlier ones, so i = 0 is the highest-priority candidate
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = RR ? 3'(last + 3'(i) + 3'd1) : 3'(7 - i);
      if (pend[idx]) sel = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      gs_n <= 1'b1;
      ovf <= 1'b0;
      code <= '0;
      last <= 3'd7;
    end else begin
      state <= state_next;
      pend <= pend_next;
      gs_n <= ~|pend_next;
      ovf <= |(fall & pend & ~clr);
      if (load) code <= sel;
      if (hs) last <= code;
    end
endmodule
